// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one sram-like master port among NREQ requesters.
// One transaction in flight at a time; the response returns only to its owner.
module sram_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 64,
  parameter int DW   = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NREQ-1:0]    s_req,
  input  logic [NREQ-1:0]    s_wr,
  input  logic [2*NREQ-1:0]  s_size,
  input  logic [AW*NREQ-1:0] s_addr,
  input  logic [DW*NREQ-1:0] s_wdata,
  output logic [NREQ-1:0]    s_addr_ok,
  output logic [NREQ-1:0]    s_data_ok,
  output logic [DW-1:0]      s_rdata,
  output logic               m_req,
  output logic               m_wr,
  output logic [1:0]         m_size,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  input  logic               m_addr_ok,
  input  logic               m_data_ok,
  input  logic [DW-1:0]      m_rdata,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned N = NREQ;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic            wr_q, wr_d;
  logic [1:0]      size_q, size_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [PW-1:0]   winner;
  logic            found;
  int unsigned     idx_c;

  // Rotating priority scan starting at ptr_q, wrapping modulo NREQ.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx_c  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = 32'(ptr_q) + k;
      if (idx_c >= N) idx_c = idx_c - N;
      if (!found && s_req[idx_c[PW-1:0]]) begin
        found  = 1'b1;
        winner = idx_c[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    s_addr_ok = '0;
    s_data_ok = '0;
    s_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          s_addr_ok[winner] = 1'b1;
          owner_d           = winner;
          state_d           = ISSUE;
          for (int unsigned i = 0; i < N; i++) begin
            if (PW'(i) == winner) begin
              wr_d    = s_wr[i];
              size_d  = s_size[2*i +: 2];
              addr_d  = s_addr[AW*i +: AW];
              wdata_d = s_wdata[DW*i +: DW];
            end
          end
        end
      end
      ISSUE: begin
        if (m_addr_ok) state_d = WAIT;
      end
      WAIT: begin
        if (m_data_ok) begin
          s_data_ok[owner_q] = 1'b1;
          s_rdata            = m_rdata;
          ptr_d              = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;
          state_d            = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so the strobes must be masked combinationally during it.
    if (reset) begin
      s_addr_ok = '0;
      s_data_ok = '0;
      s_rdata   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    m_req    = 1'b0;
    busy     = 1'b0;
    m_wr     = 1'b0;
    m_size   = '0;
    m_addr   = '0;
    m_wdata  = '0;
    grant_id = '0;
    if (!reset) begin
      m_req             = (state_q == ISSUE);
      busy              = (state_q != IDLE);
      m_wr              = wr_q;
      m_size            = size_q;
      m_addr            = addr_q;
      m_wdata           = wdata_q;
      grant_id[PW-1:0]  = owner_q;
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: cycle table plus reset and round-robin sequences.
module tb_sram_rr_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 64;
  localparam int DW   = 64;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    s_req = '0;
  logic [NREQ-1:0]    s_wr;
  logic [2*NREQ-1:0]  s_size;
  logic [AW*NREQ-1:0] s_addr;
  logic [DW*NREQ-1:0] s_wdata;
  logic [NREQ-1:0]    s_addr_ok;
  logic [NREQ-1:0]    s_data_ok;
  logic [DW-1:0]      s_rdata;
  logic               m_req;
  logic               m_wr;
  logic [1:0]         m_size;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_wdata;
  logic               m_addr_ok = 1'b0;
  logic               m_data_ok = 1'b0;
  logic [DW-1:0]      m_rdata = '0;
  logic               busy;
  logic [2:0]         grant_id;

  int total = 0;
  int bad   = 0;

  sram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic        aok;
    logic        dok;
    logic [63:0] rdata;
    logic [2:0]  e_aok;
    logic [2:0]  e_dok;
    logic [63:0] e_rdata;
    logic        e_mreq;
    logic        e_busy;
    logic [2:0]  e_gid;
    logic        chk_m;
    logic [63:0] e_maddr;
    logic        e_mwr;
    logic [1:0]  e_msize;
    logic [63:0] e_mwdata;
  } vec_t;

  vec_t vt[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 2 time units later.
  task automatic drive(input logic r, input logic [2:0] rq, input logic ao,
                       input logic dk, input logic [63:0] rd);
    @(negedge clock);
    reset = r; s_req = rq; m_addr_ok = ao; m_data_ok = dk; m_rdata = rd;
    #2;
  endtask

  initial begin
    s_wr    = 3'b001;
    s_size  = {2'd2, 2'd3, 2'd0};
    s_addr  = {64'h2000, 64'h8000_0010, 64'h1004};
    s_wdata = {64'h2222, 64'h1111, 64'hAB};

    //          rst req    aok dok rdata                  e_aok  e_dok  e_rdata                mreq busy gid  chk maddr          mwr sz  wdata
    vt[0]  = '{1'b1, 3'b111, 1'b0, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b0, 1'b0, 3'd0, 1'b1, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[1]  = '{1'b0, 3'b000, 1'b0, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b0, 1'b0, 3'd0, 1'b1, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[2]  = '{1'b0, 3'b010, 1'b1, 1'b0, 64'h0,                 3'b010, 3'b000, 64'h0,                 1'b0, 1'b0, 3'd0, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[3]  = '{1'b0, 3'b000, 1'b1, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b1, 1'b1, 3'd1, 1'b1, 64'h8000_0010, 1'b0, 2'd3, 64'h1111};
    vt[4]  = '{1'b0, 3'b000, 1'b1, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b0, 1'b1, 3'd1, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[5]  = vt[4];
    vt[6]  = '{1'b0, 3'b000, 1'b1, 1'b1, 64'hDEAD_BEEF_0123_4567, 3'b000, 3'b010, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1, 3'd1, 1'b0, 64'h0,    1'b0, 2'd0, 64'h0};
    // ptr is now 2: requesters 0 and 1 compete, scan wraps to 0.
    vt[7]  = '{1'b0, 3'b011, 1'b0, 1'b0, 64'h0,                 3'b001, 3'b000, 64'h0,                 1'b0, 1'b0, 3'd1, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[8]  = '{1'b0, 3'b010, 1'b0, 1'b1, 64'h5555,              3'b000, 3'b000, 64'h0,                 1'b1, 1'b1, 3'd0, 1'b1, 64'h1004,      1'b1, 2'd0, 64'hAB};
    vt[9]  = '{1'b0, 3'b010, 1'b0, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b1, 1'b1, 3'd0, 1'b1, 64'h1004,      1'b1, 2'd0, 64'hAB};
    vt[10] = vt[9];
    vt[11] = vt[9];
    vt[12] = vt[9];
    vt[13] = '{1'b0, 3'b010, 1'b1, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b1, 1'b1, 3'd0, 1'b1, 64'h1004,      1'b1, 2'd0, 64'hAB};
    vt[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 64'h0,                 3'b000, 3'b000, 64'h0,                 1'b0, 1'b1, 3'd0, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[15] = '{1'b0, 3'b000, 1'b0, 1'b1, 64'hCAFE,              3'b000, 3'b001, 64'hCAFE,              1'b0, 1'b1, 3'd0, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};
    vt[16] = '{1'b0, 3'b000, 1'b0, 1'b1, 64'h77,                3'b000, 3'b000, 64'h0,                 1'b0, 1'b0, 3'd0, 1'b0, 64'h0,         1'b0, 2'd0, 64'h0};

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].req, vt[i].aok, vt[i].dok, vt[i].rdata);
      check($sformatf("v%0d s_addr_ok", i), 64'(s_addr_ok), 64'(vt[i].e_aok));
      check($sformatf("v%0d s_data_ok", i), 64'(s_data_ok), 64'(vt[i].e_dok));
      check($sformatf("v%0d s_rdata", i), s_rdata, vt[i].e_rdata);
      check($sformatf("v%0d m_req", i), 64'(m_req), 64'(vt[i].e_mreq));
      check($sformatf("v%0d busy", i), 64'(busy), 64'(vt[i].e_busy));
      check($sformatf("v%0d grant_id", i), 64'(grant_id), 64'(vt[i].e_gid));
      if (vt[i].chk_m) begin
        check($sformatf("v%0d m_addr", i), m_addr, vt[i].e_maddr);
        check($sformatf("v%0d m_wr", i), 64'(m_wr), 64'(vt[i].e_mwr));
        check($sformatf("v%0d m_size", i), 64'(m_size), 64'(vt[i].e_msize));
        check($sformatf("v%0d m_wdata", i), m_wdata, vt[i].e_mwdata);
      end
    end

    // Reset mid-transaction: ptr=1, so requester 2 wins, then reset in WAIT.
    drive(1'b0, 3'b100, 1'b1, 1'b0, 64'h0);
    check("rst_seq accept", 64'(s_addr_ok), 64'(3'b100));
    drive(1'b0, 3'b000, 1'b1, 1'b0, 64'h0);
    check("rst_seq issue m_req", 64'(m_req), 64'd1);
    check("rst_seq issue gid", 64'(grant_id), 64'd2);
    check("rst_seq issue m_addr", m_addr, 64'h2000);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 64'h0);
    check("rst_seq wait busy", 64'(busy), 64'd1);
    drive(1'b1, 3'b111, 1'b0, 1'b0, 64'h0);
    check("rst_in busy", 64'(busy), 64'd0);
    check("rst_in m_req", 64'(m_req), 64'd0);
    check("rst_in s_addr_ok", 64'(s_addr_ok), 64'd0);
    check("rst_in s_data_ok", 64'(s_data_ok), 64'd0);
    check("rst_in grant_id", 64'(grant_id), 64'd0);
    check("rst_in m_addr", m_addr, 64'h0);
    check("rst_in m_wdata", m_wdata, 64'h0);
    drive(1'b0, 3'b000, 1'b0, 1'b1, 64'h99);
    check("rst_after s_data_ok", 64'(s_data_ok), 64'd0);
    check("rst_after s_rdata", s_rdata, 64'h0);
    check("rst_after busy", 64'(busy), 64'd0);

    // Round-robin with all requesters held high; ptr restarted at 0.
    for (int t = 0; t < 6; t++) begin
      logic [2:0] exp_oh;
      exp_oh = 3'b001 << (t % 3);
      drive(1'b0, 3'b111, 1'b1, 1'b0, 64'h0);
      check($sformatf("rr%0d grant", t), 64'(s_addr_ok), 64'(exp_oh));
      drive(1'b0, 3'b111, 1'b1, 1'b0, 64'h0);
      check($sformatf("rr%0d issue no accept", t), 64'(s_addr_ok), 64'd0);
      check($sformatf("rr%0d grant_id", t), 64'(grant_id), 64'(t % 3));
      drive(1'b0, 3'b111, 1'b1, 1'b1, 64'(t + 16));
      check($sformatf("rr%0d s_data_ok", t), 64'(s_data_ok), 64'(exp_oh));
      check($sformatf("rr%0d s_rdata", t), s_rdata, 64'(t + 16));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
